// File: rtl/btn_ev_pkg.sv
// rtl/btn_ev_pkg.sv - shared channel state encoding and event codes for the button front end
package btn_ev_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_DB,
    HELD,
    LONG,
    REL_DB
  } chan_state_t;

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_LONG    = 2'b11;

  // bit positions inside a channel's 3-bit pending vector
  localparam int PB_PRESS = 0;
  localparam int PB_LONG  = 1;
  localparam int PB_REL   = 2;

endpackage

// File: rtl/btn_chan_fsm.sv
// rtl/btn_chan_fsm.sv - one button channel: 2-FF sync, tick-sampled debounce and press/release/long classification
module btn_chan_fsm
  import btn_ev_pkg::*;
#(
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic ev_press,
  output logic ev_release,
  output logic ev_long
);

  localparam int CNT_W = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             long_done_q, long_done_d;
  logic             sync1_q, sync2_q;
  logic             s;

  assign s     = sync2_q;
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      long_done_q <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      long_done_q <= long_done_d;
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
    end
  end

  // strobes are combinational on the tick cycle so the top can latch them into pending at the same edge
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    long_done_d = long_done_q;
    ev_press    = 1'b0;
    ev_release  = 1'b0;
    ev_long     = 1'b0;
    if (tick) begin
      unique case (state_q)
        RELEASED: begin
          if (s) begin
            state_d = PRESS_DB;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_DB: begin
          if (!s) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d  = HELD;
            cnt_d    = '0;
            level_d  = 1'b1;
            ev_press = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state_d = REL_DB;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == LONG_LAST) begin
            state_d     = LONG;
            long_done_d = 1'b1;
            ev_long     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LONG: begin
          if (!s) begin
            state_d = REL_DB;
            cnt_d   = CNT_W'(1);
          end
        end
        REL_DB: begin
          if (s) begin
            // a bounce back restarts the long timer but never re-arms LONG
            state_d = long_done_q ? LONG : HELD;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d     = RELEASED;
            cnt_d       = '0;
            level_d     = 1'b0;
            long_done_d = 1'b0;
            ev_release  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - multi-button front end: tick prescaler, per-channel FSMs, pending/overflow, round-robin event port
module btn_event_ctrl
  import btn_ev_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         btn_in,
  input  logic                     ev_ready,
  input  logic                     ovf_clr,
  output logic [N_BTN-1:0]         level,
  output logic                     ev_valid,
  output logic [$clog2(N_BTN)-1:0] ev_id,
  output logic [1:0]               ev_code,
  output logic [N_BTN-1:0]         overflow
);

  localparam int ID_W  = $clog2(N_BTN);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]       pre_q, pre_d;
  logic                   tick;
  logic [N_BTN-1:0]       str_press, str_long, str_rel;
  logic [N_BTN-1:0][2:0]  pend_q, pend_d;
  logic [N_BTN-1:0]       ovf_q, ovf_d;
  logic                   ev_valid_q, ev_valid_d;
  logic [ID_W-1:0]        ev_id_q, ev_id_d;
  logic [1:0]             ev_code_q, ev_code_d;
  logic [ID_W-1:0]        rr_q, rr_d;

  assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_chan_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .btn_raw   (btn_in[g]),
      .level     (level[g]),
      .ev_press  (str_press[g]),
      .ev_release(str_rel[g]),
      .ev_long   (str_long[g])
    );
  end

  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    logic [2:0]      set_v;
    pend_d     = pend_q;
    ovf_d      = ovf_clr ? '0 : ovf_q;
    ev_valid_d = ev_valid_q;
    ev_id_d    = ev_id_q;
    ev_code_d  = ev_code_q;
    rr_d       = rr_q;
    found      = 1'b0;
    idx        = '0;
    set_v      = '0;
    if (!ev_valid_q || ev_ready) begin
      ev_valid_d = 1'b0;
      for (int k = 1; k <= N_BTN; k++) begin
        idx = ID_W'((int'(rr_q) + k) % N_BTN);
        if (!found && (pend_q[idx] != 3'b000)) begin
          found      = 1'b1;
          ev_valid_d = 1'b1;
          ev_id_d    = idx;
          rr_d       = idx;
          if (pend_q[idx][PB_PRESS]) begin
            ev_code_d              = EV_PRESS;
            pend_d[idx][PB_PRESS]  = 1'b0;
          end else if (pend_q[idx][PB_LONG]) begin
            ev_code_d              = EV_LONG;
            pend_d[idx][PB_LONG]   = 1'b0;
          end else begin
            ev_code_d              = EV_RELEASE;
            pend_d[idx][PB_REL]    = 1'b0;
          end
        end
      end
    end
    // pend_d already has this cycle's grant removed, so grant+set of one bit is not an overflow
    for (int i = 0; i < N_BTN; i++) begin
      set_v     = {str_rel[i], str_long[i], str_press[i]};
      if ((set_v & pend_d[i]) != 3'b000) ovf_d[i] = 1'b1;
      pend_d[i] = pend_d[i] | set_v;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      pend_q     <= '0;
      ovf_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      ev_code_q  <= 2'b00;
      rr_q       <= '0;
    end else begin
      pre_q      <= pre_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      ev_valid_q <= ev_valid_d;
      ev_id_q    <= ev_id_d;
      ev_code_q  <= ev_code_d;
      rr_q       <= rr_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_id    = ev_id_q;
  assign ev_code  = ev_code_q;
  assign overflow = ovf_q;

endmodule
